// File: rtl/sdram_aref.sv
// SDRAM auto-refresh generator: periodic request, then PRECHARGE-ALL followed by
// AREF_NUM AUTO-REFRESH commands with tRP/tRC NOP spacing, ending in a one-cycle ar_end.
module sdram_aref #(
    parameter int unsigned CNT_REF_MAX = 750,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned TRP_CLK     = 2,
    parameter int unsigned TRC_CLK     = 7,
    parameter int unsigned AREF_NUM    = 2
) (
    input  logic        aref_clk,
    input  logic        aref_rst_n,
    input  logic        init_end,
    input  logic        ar_en,
    output logic        ar_req,
    output logic        ar_end,
    output logic        ar_late,
    output logic [3:0]  ar_cmd,
    output logic [1:0]  ar_bank,
    output logic [12:0] ar_addr
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned REF_W  = 2;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_TRP,
        S_REF,
        S_TRC,
        S_END
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [REF_W-1:0]    ref_cnt_q, ref_cnt_d;
    logic                ar_req_q, ar_req_d;
    logic                ar_late_q, ar_late_d;
    logic                wrap;
    logic                req_clr;

    always_ff @(posedge aref_clk or negedge aref_rst_n) begin
        if (!aref_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wait_q    <= '0;
            ref_cnt_q <= '0;
            ar_req_q  <= 1'b0;
            ar_late_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            ref_cnt_q <= ref_cnt_d;
            ar_req_q  <= ar_req_d;
            ar_late_q <= ar_late_d;
        end
    end

    // Free-running refresh interval counter and request/late tracking
    always_comb begin
        wrap      = (cnt_q == CNT_W'(CNT_REF_MAX - 1)) && init_end;
        req_clr   = (state_q == S_IDLE) && ar_en;
        cnt_d     = cnt_q;
        ar_req_d  = ar_req_q;
        ar_late_d = 1'b0;
        if (!init_end) begin
            cnt_d    = '0;
            ar_req_d = 1'b0;
        end else begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            if (wrap) begin
                ar_req_d  = 1'b1;
                ar_late_d = ar_req_q && !req_clr;
            end else if (req_clr) begin
                ar_req_d = 1'b0;
            end
        end
    end

    // Sequencer next-state; wait counter reloads on entry to the wait states
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ref_cnt_d = ref_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ar_en) begin
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                state_d = S_TRP;
                wait_d  = WAIT_W'(TRP_CLK - 1);
            end
            S_TRP: begin
                if (wait_q == '0) begin
                    state_d = S_REF;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_REF: begin
                state_d   = S_TRC;
                wait_d    = WAIT_W'(TRC_CLK - 1);
                ref_cnt_d = ref_cnt_q + REF_W'(1);
            end
            S_TRC: begin
                if (wait_q == '0) begin
                    state_d = (ref_cnt_q < REF_W'(AREF_NUM)) ? S_REF : S_END;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_END: begin
                state_d   = S_IDLE;
                ref_cnt_d = '0;
            end
            default: begin
                state_d   = S_IDLE;
                wait_d    = '0;
                ref_cnt_d = '0;
            end
        endcase
    end

    // Command decode straight from the state flop so reset forces NOP at once
    always_comb begin
        ar_cmd = CMD_NOP;
        case (state_q)
            S_PRE:   ar_cmd = CMD_PRE;
            S_REF:   ar_cmd = CMD_AREF;
            default: ar_cmd = CMD_NOP;
        endcase
    end

    assign ar_end  = (state_q == S_END);
    assign ar_req  = ar_req_q;
    assign ar_late = ar_late_q;
    assign ar_bank = 2'b11;
    assign ar_addr = 13'h1fff;

endmodule

// File: tb/tb_sdram_aref.sv
// Directed self-checking bench for sdram_aref with default parameters.
module tb_sdram_aref;

    logic        aref_clk;
    logic        aref_rst_n;
    logic        init_end;
    logic        ar_en;
    logic        ar_req;
    logic        ar_end;
    logic        ar_late;
    logic [3:0]  ar_cmd;
    logic [1:0]  ar_bank;
    logic [12:0] ar_addr;

    int checks;
    int failures;
    int edges;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;

    sdram_aref dut (
        .aref_clk   (aref_clk),
        .aref_rst_n (aref_rst_n),
        .init_end   (init_end),
        .ar_en      (ar_en),
        .ar_req     (ar_req),
        .ar_end     (ar_end),
        .ar_late    (ar_late),
        .ar_cmd     (ar_cmd),
        .ar_bank    (ar_bank),
        .ar_addr    (ar_addr)
    );

    initial aref_clk = 1'b0;
    always #5 aref_clk = ~aref_clk;

    // One clock: active edge, then sample on the falling edge
    task automatic step();
        @(posedge aref_clk);
        @(negedge aref_clk);
        edges++;
    endtask

    task automatic test_reset();
        aref_rst_n = 1'b1;
        init_end   = 1'b0;
        ar_en      = 1'b0;
        #3 aref_rst_n = 1'b0;
        #1;
        checks++;
        if ({ar_req, ar_end, ar_late, ar_cmd, ar_bank, ar_addr} !== {3'b000, NOP, 2'b11, 13'h1fff}) begin
            failures++;
            $display("FAIL reset_vals got=%b exp=%b",
                     {ar_req, ar_end, ar_late, ar_cmd, ar_bank, ar_addr}, {3'b000, NOP, 2'b11, 13'h1fff});
        end
        @(negedge aref_clk);
        @(negedge aref_clk);
        aref_rst_n = 1'b1;
    endtask

    task automatic test_no_init();
        for (int i = 0; i < 1000; i++) begin
            step();
            checks++;
            if ({ar_req, ar_end, ar_late, ar_cmd, ar_bank, ar_addr} !== {3'b000, NOP, 2'b11, 13'h1fff}) begin
                failures++;
                $display("FAIL no_init cyc=%0d got=%b exp=%b", i,
                         {ar_req, ar_end, ar_late, ar_cmd, ar_bank, ar_addr}, {3'b000, NOP, 2'b11, 13'h1fff});
            end
        end
    endtask

    // Idle with no grant until edges==target; req/late follow wrap points given by edges
    task automatic idle_until(input int target, input logic req_start);
        logic req_exp;
        logic late_exp;
        req_exp = req_start;
        while (edges < target) begin
            step();
            late_exp = 1'b0;
            if (edges % 750 == 0) begin
                late_exp = req_exp;
                req_exp  = 1'b1;
            end
            checks++;
            if ({ar_req, ar_late, ar_end, ar_cmd} !== {req_exp, late_exp, 1'b0, NOP}) begin
                failures++;
                $display("FAIL idle edge=%0d req/late/end/cmd got=%b exp=%b", edges,
                         {ar_req, ar_late, ar_end, ar_cmd}, {req_exp, late_exp, 1'b0, NOP});
            end
        end
    endtask

    // Grant, check the whole 20-cycle sequence, release grant the edge after ar_end
    task automatic run_sequence(input string name, output logic req_after);
        logic       req_exp;
        logic [3:0] cmd_exp;
        ar_en   = 1'b1;
        req_exp = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (edges % 750 == 0) req_exp = 1'b1;
            cmd_exp = (i == 1) ? PRE : ((i == 4 || i == 12) ? AREF : NOP);
            checks++;
            if ({ar_cmd, ar_end, ar_req, ar_late} !== {cmd_exp, (i == 20), req_exp, 1'b0}) begin
                failures++;
                $display("FAIL %s cyc=%0d cmd/end/req/late got=%b exp=%b", name, i,
                         {ar_cmd, ar_end, ar_req, ar_late}, {cmd_exp, (i == 20), req_exp, 1'b0});
            end
        end
        @(posedge aref_clk);
        #1 ar_en = 1'b0;
        @(negedge aref_clk);
        edges++;
        if (edges % 750 == 0) req_exp = 1'b1;
        checks++;
        if ({ar_cmd, ar_end, ar_req} !== {NOP, 1'b0, req_exp}) begin
            failures++;
            $display("FAIL %s_post cmd/end/req got=%b exp=%b", name,
                     {ar_cmd, ar_end, ar_req}, {NOP, 1'b0, req_exp});
        end
        req_after = req_exp;
    endtask

    task automatic test_first_wrap();
        init_end = 1'b1;
        edges    = 0;
        idle_until(749, 1'b0);
        checks++;
        if (ar_req !== 1'b0) begin
            failures++;
            $display("FAIL pre_wrap got=%b exp=0", ar_req);
        end
        step();
        checks++;
        if ({ar_req, ar_late} !== 2'b10) begin
            failures++;
            $display("FAIL first_wrap req/late got=%b exp=10", {ar_req, ar_late});
        end
    endtask

    task automatic test_grant();
        logic r;
        run_sequence("grant", r);
        idle_until(1500, r);
        checks++;
        if (ar_req !== 1'b1) begin
            failures++;
            $display("FAIL second_wrap got=%b exp=1", ar_req);
        end
    endtask

    task automatic test_late();
        logic r;
        idle_until(3100, 1'b1);
        run_sequence("late_seq", r);
        checks++;
        if (ar_req !== 1'b0) begin
            failures++;
            $display("FAIL late_cleared got=%b exp=0", ar_req);
        end
    endtask

    task automatic test_mid_wrap();
        logic r;
        idle_until(4490, 1'b0);
        run_sequence("mid_seq1", r);
        checks++;
        if (ar_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_wrap_req got=%b exp=1", ar_req);
        end
        run_sequence("mid_seq2", r);
        checks++;
        if (ar_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_regrant_req got=%b exp=0", ar_req);
        end
    endtask

    task automatic test_reset_mid();
        ar_en = 1'b1;
        for (int i = 1; i <= 4; i++) step();
        checks++;
        if (ar_cmd !== AREF) begin
            failures++;
            $display("FAIL rst_mid_aref got=%b exp=%b", ar_cmd, AREF);
        end
        aref_rst_n = 1'b0;
        ar_en      = 1'b0;
        #1;
        checks++;
        if ({ar_req, ar_end, ar_late, ar_cmd, ar_bank, ar_addr} !== {3'b000, NOP, 2'b11, 13'h1fff}) begin
            failures++;
            $display("FAIL rst_mid_vals got=%b exp=%b",
                     {ar_req, ar_end, ar_late, ar_cmd, ar_bank, ar_addr}, {3'b000, NOP, 2'b11, 13'h1fff});
        end
        @(negedge aref_clk);
        checks++;
        if ({ar_end, ar_cmd} !== {1'b0, NOP}) begin
            failures++;
            $display("FAIL rst_mid_hold end/cmd got=%b exp=%b", {ar_end, ar_cmd}, {1'b0, NOP});
        end
        aref_rst_n = 1'b1;
        edges      = 0;
        idle_until(750, 1'b0);
        checks++;
        if (ar_req !== 1'b1) begin
            failures++;
            $display("FAIL relaunch_req got=%b exp=1", ar_req);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        edges    = 0;
        test_reset();
        test_no_init();
        test_first_wrap();
        test_grant();
        test_late();
        test_mid_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
